uart_rx: RTL and testbench

UART receiver for 8N1 serial frames; the receive-side counterpart of the team's uart_tx.
- Oversamples rx_in at 16x baud and validates the start bit at mid-bit.
- Shifts in 8 data bits LSB-first and checks the stop bit.
- Presents each byte on a valid/read-enable handshake to the RPN core.
- Flags framing errors and overruns.

---
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and valid/ren byte handshake
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DIV       = CLK_FREQ / (BAUD_RATE * 16)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] dout,
  output logic       valid,
  input  logic       ren,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state, state_n;
  logic          sync1, rx_s;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    s;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          deliver, ferr, shift_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  // Held at zero while idle so the first tick lands DIV cycles after the start edge.
  assign tick = (tick_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        tick_cnt <= '0;
    else if (state == IDLE || tick) tick_cnt <= '0;
    else                            tick_cnt <= tick_cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    deliver  = 1'b0;
    ferr     = 1'b0;
    shift_en = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_n = START;
      START: if (tick && s == 4'd7) state_n = rx_s ? IDLE : DATA;
      DATA: begin
        if (tick && s == 4'd15) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (tick && s == 4'd15) begin
          if (rx_s) begin
            deliver = 1'b1;
            state_n = IDLE;
          end else begin
            ferr    = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK:   if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= 1'b0;
      if (state == IDLE) begin
        s       <= '0;
        bit_idx <= '0;
      end else if (tick) begin
        if (state == START && s == 4'd7) s <= '0;
        else                             s <= s + 4'd1;
      end
      if (shift_en) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      // A pop in the delivery cycle frees the slot, so the new byte replaces the old one.
      if (deliver) begin
        if (!valid || ren) begin
          dout  <= shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ren) begin
        valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (DIV=1, 16 clk per bit)
module tb_uart_rx;

  logic       clk, rst, rx_in, ren;
  logic [7:0] dout;
  logic       valid, frame_err, overrun, busy;

  uart_rx #(.CLK_FREQ(1600000), .BAUD_RATE(100000)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .dout(dout), .valid(valid),
    .ren(ren), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_n;
    int         exp_ferr;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  bit         auto_ren = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  vec_t       vecs[7];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame, LSB first, 16 clk per bit; leaves the line high.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_in = 1'b0;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      idle(16);
    end
    rx_in = stop;
    idle(16);
    rx_in = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (frame_err || overrun) check("err_exclusive", {31'd0, frame_err & overrun}, 32'd0);
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (auto_ren) begin
        if (valid && !ren) begin
          got.push_back(dout);
          ren = 1'b1;
        end else begin
          ren = 1'b0;
        end
      end
    end
  end

  initial begin
    int lat, f0, o0, busy_seen;
    logic [7:0] b;
    logic       st;

    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 1};
    vecs[2] = '{8'h55, 1'b1, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 0};
    vecs[5] = '{8'h81, 1'b1, 1, 0};
    vecs[6] = '{8'h7E, 1'b0, 0, 1};

    rst = 1; rx_in = 1; ren = 0;
    idle(3);
    check("reset_outputs", {20'd0, dout, valid, frame_err, overrun, busy}, 32'd0);
    rst = 0;
    idle(5);

    // Single frame 0xA5: latency from line edge (2 sync + 153) and handshake.
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!valid && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    checks++;
    if (lat < 154 || lat > 156) begin
      failures++;
      $display("FAIL valid_latency actual=%0d expected=155+/-1", lat);
    end
    check("a5_dout", {24'd0, dout}, 32'hA5);
    check("a5_valid", {31'd0, valid}, 32'd1);
    ren = 1; idle(1); ren = 0;
    check("a5_popped", {31'd0, valid}, 32'd0);
    check("a5_no_errs", ferr_cnt + ovr_cnt, 32'd0);

    // Glitch shorter than half a bit must be rejected.
    rx_in = 0; idle(4);
    busy_seen = busy;
    rx_in = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("glitch_busy_seen", busy_seen, 32'd1);
    check("glitch_busy_drop", {31'd0, busy}, 32'd0);
    idle(20);
    check("glitch_no_valid", {31'd0, valid}, 32'd0);
    check("glitch_no_ferr", ferr_cnt, 32'd0);

    // Overrun: two frames back to back, nobody reading.
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(10);
    check("ovr_dout_kept", {24'd0, dout}, 32'h11);
    check("ovr_valid", {31'd0, valid}, 32'd1);
    check("ovr_pulses", ovr_cnt - o0, 32'd1);
    // Pop exactly on the delivery edge of the next 0x22.
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (lat - 1) @(negedge clk);
        ren = 1;
        @(negedge clk);
        ren = 0;
      end
    join
    idle(5);
    check("same_cycle_dout", {24'd0, dout}, 32'h22);
    check("same_cycle_valid", {31'd0, valid}, 32'd1);
    check("same_cycle_no_ovr", ovr_cnt - o0, 32'd1);
    ren = 1; idle(1); ren = 0;

    // Reset in the middle of bit 4 of 0xFF.
    rx_in = 0; idle(16);
    rx_in = 1; idle(64 + 8);
    rst = 1;
    idle(1);
    check("midframe_reset_outputs", {20'd0, dout, valid, frame_err, overrun, busy}, 32'd0);
    idle(2);
    rst = 0;
    idle(40);
    got.delete();
    auto_ren = 1;
    send_frame(8'h81, 1'b1);
    idle(30);
    check("post_reset_count", got.size(), 32'd1);
    if (got.size() == 1) check("post_reset_byte", {24'd0, got[0]}, 32'h81);

    // Table of single frames, each followed by an idle gap.
    foreach (vecs[k]) begin
      got.delete();
      f0 = ferr_cnt;
      send_frame(vecs[k].data, vecs[k].stop);
      idle(40);
      check($sformatf("vec%0d_count", k), got.size(), vecs[k].exp_n);
      if (got.size() == 1 && vecs[k].exp_n == 1)
        check($sformatf("vec%0d_byte", k), {24'd0, got[0]}, {24'd0, vecs[k].data});
      check($sformatf("vec%0d_ferr", k), ferr_cnt - f0, vecs[k].exp_ferr);
      check($sformatf("vec%0d_valid", k), {31'd0, valid}, 32'd0);
    end

    // Gapless burst.
    got.delete();
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(30);
    check("burst_count", got.size(), 32'd4);
    if (got.size() == 4) begin
      check("burst_b0", {24'd0, got[0]}, 32'h00);
      check("burst_b1", {24'd0, got[1]}, 32'hFF);
      check("burst_b2", {24'd0, got[2]}, 32'h5A);
      check("burst_b3", {24'd0, got[3]}, 32'hC3);
    end
    check("burst_errs", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);

    // Random frames against a frame-level model: good stop -> byte, bad stop -> one frame_err.
    got.delete();
    exp_q.delete();
    f0 = ferr_cnt; o0 = ovr_cnt;
    lat = 0;
    for (int n = 0; n < 24; n++) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      send_frame(b, st);
      if (st) begin
        exp_q.push_back(b);
        idle($urandom_range(0, 5));
      end else begin
        lat++;
        idle(24);
      end
    end
    idle(40);
    check("rand_count", got.size(), exp_q.size());
    if (got.size() == exp_q.size())
      foreach (exp_q[k]) check($sformatf("rand_byte%0d", k), {24'd0, got[k]}, {24'd0, exp_q[k]});
    check("rand_ferr", ferr_cnt - f0, lat);
    check("rand_no_ovr", ovr_cnt - o0, 32'd0);

    auto_ren = 0;
    ren = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
